instr_fetch: RTL and testbench

Instruction fetch stage of the multi-cycle CPU, directly downstream of the PC register. When the control unit signals the fetch phase, it latches the current PC and performs a req/ack read of instruction memory. It stores the returned word in the instruction register (IR) and reports completion or a fault back to the control unit. The IR output feeds instruction decode.

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: latches PC on fetch_start, does a req/ack read of instruction memory
// and loads the instruction register. Optional REQ watchdog enabled by `define IFETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic        click,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_fault
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed REQ cycles without an ack; the current cycle is number cnt_q + 1.
  assign timeout_hit = (state_q == StReq) && !imem_ack && (cnt_q >= TimeoutLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (!imem_ack && !timeout_hit) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge click or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    fault_d = 1'b0;

    if (flush) begin
      // Flush overrides everything, including a coincident ack or start.
      state_d = StIdle;
      req_d   = 1'b0;
      ir_d    = NOP_WORD;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fetch_start) begin
            if (PC[1:0] == 2'b00) begin
              state_d = StReq;
              req_d   = 1'b1;
              addr_d  = PC;
              valid_d = 1'b0;
            end else begin
              fault_d = 1'b1;
              ir_d    = NOP_WORD;
              valid_d = 1'b0;
            end
          end
        end
        StReq: begin
          if (imem_ack) begin
            state_d = StIdle;
            req_d   = 1'b0;
            ir_d    = imem_rdata;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else if (timeout_hit) begin
            state_d = StIdle;
            req_d   = 1'b0;
            ir_d    = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge click or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= NOP_WORD;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign IR          = ir_q;
  assign ir_valid    = valid_q;
  assign fetch_busy  = (state_q == StReq);
  assign fetch_done  = done_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level model compared every cycle plus
// directed literal checks. Timeout scenarios run when IFETCH_TIMEOUT_EN is defined.
module tb_instr_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam int          Tmo = 4;
`ifdef IFETCH_TIMEOUT_EN
  localparam bit TimeoutOn  = 1'b1;
  localparam int WaitStalls = 2;  // stay clear of the 4-cycle watchdog
`else
  localparam bit TimeoutOn  = 1'b0;
  localparam int WaitStalls = 5;
`endif

  logic        click;
  logic        reset;
  logic [31:0] PC;
  logic        fetch_start;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] IR;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_fault;

  int tests = 0;
  int fails = 0;

  instr_fetch #(
    .TIMEOUT_CYCLES(Tmo),
    .NOP_WORD      (Nop)
  ) dut (
    .click      (click),
    .reset      (reset),
    .PC         (PC),
    .fetch_start(fetch_start),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_fault(fetch_fault)
  );

  initial click = 1'b0;
  always #5 click = ~click;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a fetch is either outstanding or not; m_cycle is which REQ cycle we are in.
  bit          m_pending;
  logic [31:0] m_addr;
  logic [31:0] m_ir;
  bit          m_valid;
  bit          m_done;
  bit          m_fault;
  int          m_cycle;

  always @(posedge click or negedge reset) begin
    if (!reset) begin
      m_pending <= 1'b0;
      m_addr    <= 32'h0;
      m_ir      <= Nop;
      m_valid   <= 1'b0;
      m_done    <= 1'b0;
      m_fault   <= 1'b0;
      m_cycle   <= 0;
    end else begin
      m_done  <= 1'b0;
      m_fault <= 1'b0;
      if (flush) begin
        m_pending <= 1'b0;
        m_ir      <= Nop;
        m_valid   <= 1'b0;
      end else if (!m_pending) begin
        if (fetch_start && (PC % 4 == 0)) begin
          m_pending <= 1'b1;
          m_addr    <= PC;
          m_valid   <= 1'b0;
          m_cycle   <= 1;
        end else if (fetch_start) begin
          m_fault <= 1'b1;
          m_ir    <= Nop;
          m_valid <= 1'b0;
        end
      end else if (imem_ack) begin
        m_pending <= 1'b0;
        m_ir      <= imem_rdata;
        m_valid   <= 1'b1;
        m_done    <= 1'b1;
      end else if (TimeoutOn && m_cycle >= Tmo) begin
        m_pending <= 1'b0;
        m_ir      <= Nop;
        m_valid   <= 1'b0;
        m_fault   <= 1'b1;
      end else begin
        m_cycle <= m_cycle + 1;
      end
    end
  end

  always @(negedge click) begin
    check("cmp_imem_req", {31'b0, imem_req}, {31'b0, m_pending});
    check("cmp_busy", {31'b0, fetch_busy}, {31'b0, m_pending});
    check("cmp_addr", imem_addr, m_addr);
    check("cmp_ir", IR, m_ir);
    check("cmp_ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    check("cmp_done", {31'b0, fetch_done}, {31'b0, m_done});
    check("cmp_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    check("cmp_done_fault_excl", {31'b0, fetch_done & fetch_fault}, 32'h0);
  end

  task automatic tick();
    @(posedge click);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    PC          = 32'h0;
    fetch_start = 1'b0;
    flush       = 1'b0;
    imem_rdata  = 32'h0;
    imem_ack    = 1'b0;
    tick();
    tick();
    check("rst_ir", IR, Nop);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_flags", {28'b0, ir_valid, fetch_busy, fetch_done, fetch_fault}, 32'h0);
    reset = 1'b1;
    tick();

    // Normal fetch, ack in the first REQ cycle.
    PC = 32'h0000_0040;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("norm_req", {31'b0, imem_req}, 32'h1);
    check("norm_addr", imem_addr, 32'h0000_0040);
    check("norm_done_early", {31'b0, fetch_done}, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h2001_0005;
    tick();
    imem_ack = 1'b0;
    check("norm_done", {31'b0, fetch_done}, 32'h1);
    check("norm_ir", IR, 32'h2001_0005);
    check("norm_valid", {31'b0, ir_valid}, 32'h1);
    check("norm_req_drop", {31'b0, imem_req}, 32'h0);
    tick();
    check("norm_done_pulse", {31'b0, fetch_done}, 32'h0);
    check("norm_ir_hold", IR, 32'h2001_0005);

    // Wait states with ignored start pulses and a moving PC.
    PC = 32'h0000_0044;
    fetch_start = 1'b1;
    tick();
    for (int i = 0; i < WaitStalls; i++) begin
      fetch_start = i[0];
      PC = 32'h0000_0100 + 32'(i * 4);
      tick();
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h0000_0044);
      check("wait_busy", {31'b0, fetch_busy}, 32'h1);
    end
    fetch_start = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h00A0_0093;
    tick();
    imem_ack = 1'b0;
    check("wait_done", {31'b0, fetch_done}, 32'h1);
    check("wait_ir", IR, 32'h00A0_0093);
    tick();
    check("wait_idle", {31'b0, imem_req}, 32'h0);

    // Misaligned PC.
    PC = 32'h0000_0042;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("mis_req", {31'b0, imem_req}, 32'h0);
    check("mis_ir", IR, Nop);
    check("mis_valid", {31'b0, ir_valid}, 32'h0);
    tick();
    check("mis_fault_pulse", {31'b0, fetch_fault}, 32'h0);

    // Flush coincident with an ack.
    PC = 32'h0000_0050;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    flush = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0;
    imem_ack = 1'b0;
    check("fl_ir", IR, Nop);
    check("fl_flags", {28'b0, ir_valid, fetch_busy, fetch_done, fetch_fault}, 32'h0);
    check("fl_req", {31'b0, imem_req}, 32'h0);

    // Flush coincident with start in IDLE discards the start.
    PC = 32'h0000_0060;
    fetch_start = 1'b1;
    flush = 1'b1;
    tick();
    fetch_start = 1'b0;
    flush = 1'b0;
    check("flst_req", {31'b0, imem_req}, 32'h0);

    // Back-to-back: next start in the cycle fetch_done is high.
    PC = 32'h0000_0080;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h1111_2222;
    tick();
    imem_ack = 1'b0;
    check("b2b_done", {31'b0, fetch_done}, 32'h1);
    PC = 32'h0000_0084;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("b2b_req", {31'b0, imem_req}, 32'h1);
    check("b2b_addr", imem_addr, 32'h0000_0084);
    check("b2b_valid_clr", {31'b0, ir_valid}, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h3333_4444;
    tick();
    imem_ack = 1'b0;
    check("b2b_ir", IR, 32'h3333_4444);

`ifdef IFETCH_TIMEOUT_EN
    // No ack: fault after the 4th REQ cycle.
    PC = 32'h0000_00A0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < Tmo - 1; i++) tick();
    check("tmo_req_before", {31'b0, imem_req}, 32'h1);
    check("tmo_fault_before", {31'b0, fetch_fault}, 32'h0);
    tick();
    check("tmo_fault", {31'b0, fetch_fault}, 32'h1);
    check("tmo_req", {31'b0, imem_req}, 32'h0);
    check("tmo_ir", IR, Nop);
    check("tmo_valid", {31'b0, ir_valid}, 32'h0);
    // Ack in the timeout cycle wins.
    PC = 32'h0000_00A4;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < Tmo - 1; i++) tick();
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_6666;
    tick();
    imem_ack = 1'b0;
    check("tmo_ack_done", {31'b0, fetch_done}, 32'h1);
    check("tmo_ack_fault", {31'b0, fetch_fault}, 32'h0);
    check("tmo_ack_ir", IR, 32'h5555_6666);
`endif

    // Reset mid-REQ drops the request without waiting for a clock edge.
    PC = 32'h0000_0090;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("rmid_req_pre", {31'b0, imem_req}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("rmid_req", {31'b0, imem_req}, 32'h0);
    check("rmid_ir", IR, Nop);
    check("rmid_flags", {28'b0, ir_valid, fetch_busy, fetch_done, fetch_fault}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("rmid_idle", {31'b0, fetch_busy}, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
